vliw_pipe_stage: RTL and testbench



---
 rtl/vliw_pipe_stage_pkg.sv | 28 ++
 rtl/vliw_pipe_stage_if.sv | 25 ++
 rtl/vliw_pipe_stage_entry.sv | 48 ++++
 rtl/vliw_pipe_stage.sv | 155 +++++++++++++++
 tb/tb_vliw_pipe_stage.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vliw_pipe_stage_pkg.sv
//------------------------------------------------------------------------------
// Module  : vliw_pipe_pkg
// Brief   : Shared types, default sizes and lane helper for the VLIW pipe stage.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package vliw_pipe_pkg;

  localparam int C_LANES  = 2;
  localparam int C_LANE_W = 32;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  function automatic logic [C_LANE_W-1:0] lane_slice(
    input logic [C_LANES*C_LANE_W-1:0] bus,
    input int                          idx
  );
    return bus[idx*C_LANE_W +: C_LANE_W];
  endfunction

endpackage

`default_nettype wire

// File: rtl/vliw_pipe_stage_if.sv
//------------------------------------------------------------------------------
// Module  : vliw_pipe_stage_if
// Brief   : Valid/ready bundle channel; master drives the bundle, slave returns ready.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface vliw_pipe_stage_if
  import vliw_pipe_pkg::*;
#(
  parameter int LANES  = C_LANES,
  parameter int LANE_W = C_LANE_W
);

  logic                    valid;
  logic                    ready;
  logic [LANES*LANE_W-1:0] data;
  logic [LANES-1:0]        lane_vld;

  modport master (output valid, output data, output lane_vld, input ready);
  modport slave  (input valid, input data, input lane_vld, output ready);

endinterface

`default_nettype wire

// File: rtl/vliw_pipe_stage_entry.sv
//------------------------------------------------------------------------------
// Module  : vliw_pipe_entry
// Brief   : One bundle register with load, per-lane kill and lane-valid clear.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vliw_pipe_entry
  import vliw_pipe_pkg::*;
#(
  parameter int LANES  = C_LANES,
  parameter int LANE_W = C_LANE_W
) (
  input  wire logic                    clk,
  input  wire logic                    reset,
  input  wire logic                    i_load,
  input  wire logic                    i_clear,
  input  wire logic [LANES-1:0]        i_kill,
  input  wire logic [LANES*LANE_W-1:0] i_data,
  input  wire logic [LANES-1:0]        i_lane_vld,
  output logic      [LANES*LANE_W-1:0] o_data,
  output logic      [LANES-1:0]        o_lane_vld
);

  logic [LANES*LANE_W-1:0] r_data;
  logic [LANES-1:0]        r_lane_vld;

  // Payload bits are never cleared except by reset; only the lane valids squash.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data     <= '0;
      r_lane_vld <= '0;
    end else if (i_load) begin
      r_data     <= i_data;
      r_lane_vld <= i_lane_vld;
    end else if (i_clear) begin
      r_lane_vld <= '0;
    end else begin
      r_lane_vld <= r_lane_vld & ~i_kill;
    end
  end

  assign o_data     = r_data;
  assign o_lane_vld = r_lane_vld;

endmodule

`default_nettype wire

// File: rtl/vliw_pipe_stage.sv
//------------------------------------------------------------------------------
// Module  : vliw_pipe_stage
// Brief   : Elastic VLIW pipeline register with 2-entry skid, flush and lane kill.
//           Optional stall counter built when VLIW_PIPE_STALL_CNT_EN is defined.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vliw_pipe_stage
  import vliw_pipe_pkg::*;
#(
  parameter int LANES      = C_LANES,
  parameter int LANE_W     = C_LANE_W,
  parameter bit DROP_EMPTY = 1'b1
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             flush,
  input  wire logic [LANES-1:0] kill,
  vliw_pipe_stage_if.slave      up,
  vliw_pipe_stage_if.master     dn,
  output logic      [31:0]      stall_cycles
);

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic                    r_in_ready;
  logic [LANES-1:0]        w_lv_in;
  logic                    w_accept;
  logic                    w_store;
  logic                    w_out_valid;
  logic                    w_pop;
  logic                    w_main_load;
  logic                    w_skid_load;
  logic                    w_main_from_skid;
  logic [LANES*LANE_W-1:0] w_main_data;
  logic [LANES-1:0]        w_main_lv;
  logic [LANES*LANE_W-1:0] w_skid_data;
  logic [LANES-1:0]        w_skid_lv;
  logic [LANES*LANE_W-1:0] w_main_data_ld;
  logic [LANES-1:0]        w_main_lv_ld;

  assign w_lv_in     = up.lane_vld & ~kill;
  assign w_accept    = up.valid & r_in_ready;
  // An all-squashed bundle completes its handshake but is never stored.
  assign w_store     = w_accept & ~(DROP_EMPTY & (w_lv_in == '0));
  assign w_out_valid = (r_state != ST_EMPTY);
  assign w_pop       = w_out_valid & dn.ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_main_load      = 1'b0;
    w_skid_load      = 1'b0;
    w_main_from_skid = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_store) begin
          w_state_nxt = ST_ONE;
          w_main_load = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_store && !w_pop) begin
          w_state_nxt = ST_TWO;
          w_skid_load = 1'b1;
        end else if (w_store && w_pop) begin
          w_main_load = 1'b1;
        end else if (w_pop) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (w_pop) begin
          w_state_nxt      = ST_ONE;
          w_main_load      = 1'b1;
          w_main_from_skid = 1'b1;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
    if (flush) begin
      w_state_nxt = ST_EMPTY;
      w_main_load = 1'b0;
      w_skid_load = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != ST_TWO);
    end
  end

  // The skid entry moving up into main is squashed by this cycle's kill too.
  assign w_main_data_ld = w_main_from_skid ? w_skid_data : up.data;
  assign w_main_lv_ld   = w_main_from_skid ? (w_skid_lv & ~kill) : w_lv_in;

  vliw_pipe_entry #(
    .LANES  (LANES),
    .LANE_W (LANE_W)
  ) u_main (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_main_load),
    .i_clear    (flush),
    .i_kill     (kill),
    .i_data     (w_main_data_ld),
    .i_lane_vld (w_main_lv_ld),
    .o_data     (w_main_data),
    .o_lane_vld (w_main_lv)
  );

  vliw_pipe_entry #(
    .LANES  (LANES),
    .LANE_W (LANE_W)
  ) u_skid (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_skid_load),
    .i_clear    (flush),
    .i_kill     (kill),
    .i_data     (up.data),
    .i_lane_vld (w_lv_in),
    .o_data     (w_skid_data),
    .o_lane_vld (w_skid_lv)
  );

  assign up.ready    = r_in_ready;
  assign dn.valid    = w_out_valid;
  assign dn.data     = w_main_data;
  assign dn.lane_vld = w_main_lv;

`ifdef VLIW_PIPE_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_out_valid && !dn.ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cnt;
`else
  assign stall_cycles = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vliw_pipe_stage.sv
//------------------------------------------------------------------------------
// Module  : tb_vliw_pipe_stage
// Brief   : Scoreboard bench for vliw_pipe_stage (LANES=2, LANE_W=32).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_vliw_pipe_stage;
  import vliw_pipe_pkg::*;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  lv;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [1:0]  kill;
  logic [31:0] stall_cycles;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];

  vliw_pipe_stage_if #(.LANES(2), .LANE_W(32)) up_if ();
  vliw_pipe_stage_if #(.LANES(2), .LANE_W(32)) dn_if ();

  vliw_pipe_stage #(
    .LANES      (2),
    .LANE_W     (32),
    .DROP_EMPTY (1'b1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .kill         (kill),
    .up           (up_if),
    .dn           (dn_if),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  // Reference model: pop on transfer, then squash held entries, then store new.
  always @(negedge clk) begin
    if (!reset) begin
      if (dn_if.valid && dn_if.ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got data=%h lv=%b, expected nothing", dn_if.data, dn_if.lane_vld);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if ({dn_if.data, dn_if.lane_vld} !== {e.data, e.lv}) begin
            errors++;
            $display("FAIL sb_compare: got data=%h lv=%b, expected data=%h lv=%b",
                     dn_if.data, dn_if.lane_vld, e.data, e.lv);
          end
        end
      end
      if (flush) begin
        sb.delete();
      end else begin
        foreach (sb[i]) sb[i].lv = sb[i].lv & ~kill;
        if (up_if.valid && up_if.ready && ((up_if.lane_vld & ~kill) != 2'b00)) begin
          exp_t n;
          n.data = up_if.data;
          n.lv   = up_if.lane_vld & ~kill;
          sb.push_back(n);
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] d, input logic [1:0] lv, input logic [1:0] kl);
    int n;
    n = 0;
    up_if.valid    = 1'b1;
    up_if.data     = d;
    up_if.lane_vld = lv;
    while (!up_if.ready && n < 20) begin
      cycle();
      n++;
    end
    checks++;
    if (!up_if.ready) begin
      errors++;
      $display("FAIL send_timeout: in_ready=%b, expected 1", up_if.ready);
    end
    kill = kl;
    cycle();
    up_if.valid = 1'b0;
    kill        = 2'b00;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    dn_if.ready = 1'b1;
    while (sb.size() != 0 && n < 20) begin
      cycle();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d bundles left, expected 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycle();
    cycle();
    checks++;
    if (dn_if.valid !== 1'b0 || dn_if.data !== 64'd0 || dn_if.lane_vld !== 2'b00 ||
        up_if.ready !== 1'b1 || stall_cycles !== 32'd0) begin
      errors++;
      $display("FAIL reset_values: got v=%b d=%h lv=%b rdy=%b st=%0d, expected 0 0 00 1 0",
               dn_if.valid, dn_if.data, dn_if.lane_vld, up_if.ready, stall_cycles);
    end
    reset = 1'b0;
    cycle();
  endtask

  task automatic test_single();
    dn_if.ready = 1'b1;
    send({32'hBBBB0002, 32'hAAAA0001}, 2'b11, 2'b00);
    checks++;
    if (dn_if.valid !== 1'b1 || dn_if.data !== {32'hBBBB0002, 32'hAAAA0001} || dn_if.lane_vld !== 2'b11) begin
      errors++;
      $display("FAIL single_out: got v=%b d=%h lv=%b, expected 1 bbbb0002aaaa0001 11",
               dn_if.valid, dn_if.data, dn_if.lane_vld);
    end
    checks++;
    if (lane_slice(dn_if.data, 1) !== 32'hBBBB0002) begin
      errors++;
      $display("FAIL single_lane1: got %h, expected bbbb0002", lane_slice(dn_if.data, 1));
    end
    cycle();
    checks++;
    if (dn_if.valid !== 1'b0) begin
      errors++;
      $display("FAIL single_empty: got out_valid=%b, expected 0", dn_if.valid);
    end
  endtask

  task automatic test_stall();
    dn_if.ready = 1'b0;
    send(64'h1111_0001_1111_0000, 2'b11, 2'b00);
    send(64'h2222_0001_2222_0000, 2'b11, 2'b00);
    checks++;
    if (up_if.ready !== 1'b0 || dn_if.valid !== 1'b1 || dn_if.data !== 64'h1111_0001_1111_0000) begin
      errors++;
      $display("FAIL stall_full: got rdy=%b v=%b d=%h, expected 0 1 1111000111110000",
               up_if.ready, dn_if.valid, dn_if.data);
    end
    dn_if.ready = 1'b1;
    send(64'h3333_0001_3333_0000, 2'b11, 2'b00);
    drain("stall");
    checks++;
    if (dn_if.valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_end: got out_valid=%b, expected 0", dn_if.valid);
    end
  endtask

  task automatic test_kill();
    dn_if.ready = 1'b0;
    send(64'h4444_0001_4444_0000, 2'b11, 2'b00);
    kill = 2'b01;
    cycle();
    kill = 2'b00;
    checks++;
    if (dn_if.valid !== 1'b1 || dn_if.lane_vld !== 2'b10) begin
      errors++;
      $display("FAIL kill_held: got v=%b lv=%b, expected 1 10", dn_if.valid, dn_if.lane_vld);
    end
    drain("kill");
    send(64'h5555_0001_5555_0000, 2'b01, 2'b01);
    checks++;
    if (dn_if.valid !== 1'b0) begin
      errors++;
      $display("FAIL kill_drop: got out_valid=%b, expected 0", dn_if.valid);
    end
    cycle();
    checks++;
    if (dn_if.valid !== 1'b0 || up_if.ready !== 1'b1) begin
      errors++;
      $display("FAIL kill_drop_hold: got v=%b rdy=%b, expected 0 1", dn_if.valid, up_if.ready);
    end
  endtask

  task automatic test_flush();
    dn_if.ready = 1'b0;
    send(64'h6666_0001_6666_0000, 2'b11, 2'b00);
    send(64'h7777_0001_7777_0000, 2'b11, 2'b00);
    up_if.valid    = 1'b1;
    up_if.data     = 64'h8888_0001_8888_0000;
    up_if.lane_vld = 2'b11;
    flush          = 1'b1;
    cycle();
    flush       = 1'b0;
    up_if.valid = 1'b0;
    checks++;
    if (dn_if.valid !== 1'b0 || up_if.ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_state: got v=%b rdy=%b, expected 0 1", dn_if.valid, up_if.ready);
    end
    dn_if.ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    checks++;
    if (dn_if.valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_quiet: got out_valid=%b, expected 0", dn_if.valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] lvs[6];
    logic [1:0] kls[6];
    lvs = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b11, 2'b11};
    kls = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00};
    dn_if.ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (up_if.ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready[%0d]: got %b, expected 1", i, up_if.ready);
      end
      up_if.valid    = 1'b1;
      up_if.data     = {32'hC0DE0000 + 32'(i), 32'h0000F000 + 32'(i)};
      up_if.lane_vld = lvs[i];
      kill           = kls[i];
      cycle();
    end
    up_if.valid = 1'b0;
    kill        = 2'b00;
    drain("b2b");
  endtask

  task automatic test_async_reset();
    dn_if.ready = 1'b0;
    send(64'h9999_0001_9999_0000, 2'b11, 2'b00);
    checks++;
    if (dn_if.valid !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: got out_valid=%b, expected 1", dn_if.valid);
    end
    #2;
    reset = 1'b1;
    sb.delete();
    #1;
    checks++;
    if (dn_if.valid !== 1'b0 || dn_if.data !== 64'd0 || dn_if.lane_vld !== 2'b00 || up_if.ready !== 1'b1) begin
      errors++;
      $display("FAIL areset_now: got v=%b d=%h lv=%b rdy=%b, expected 0 0 00 1",
               dn_if.valid, dn_if.data, dn_if.lane_vld, up_if.ready);
    end
    cycle();
    reset = 1'b0;
    cycle();
  endtask

  task automatic test_stall_cnt();
    logic [31:0] exp_cnt;
`ifdef VLIW_PIPE_STALL_CNT_EN
    exp_cnt = 32'd5;
`else
    exp_cnt = 32'd0;
`endif
    reset = 1'b1;
    cycle();
    reset       = 1'b0;
    dn_if.ready = 1'b0;
    send(64'hAAAA_0001_AAAA_0000, 2'b11, 2'b00);
    for (int i = 0; i < 5; i++) cycle();
    checks++;
    if (stall_cycles !== exp_cnt) begin
      errors++;
      $display("FAIL stall_cnt: got %0d, expected %0d", stall_cycles, exp_cnt);
    end
    drain("cnt");
    cycle();
    checks++;
    if (stall_cycles !== exp_cnt) begin
      errors++;
      $display("FAIL stall_cnt_hold: got %0d, expected %0d", stall_cycles, exp_cnt);
    end
  endtask

  initial begin
    reset          = 1'b1;
    flush          = 1'b0;
    kill           = 2'b00;
    up_if.valid    = 1'b0;
    up_if.data     = '0;
    up_if.lane_vld = 2'b00;
    dn_if.ready    = 1'b0;
    test_reset();
    test_single();
    test_stall();
    test_kill();
    test_flush();
    test_back_to_back();
    test_async_reset();
    test_stall_cnt();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d bundles, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
